paddle_ctrl: RTL and testbench

Generates the two paddle centre positions p_1 and p_2 consumed by the pong game state machine. It synchronises and debounces the four raw push-buttons. Paddle motion is stepped on a divided frame tick, and the paddle centres are clamped so the full 80-line paddle stays on a 480-line screen. Player 2 can optionally be driven by a simple ball-tracking AI, using the ball y coordinate fed back from the state machine.

---
 rtl/paddle_ctrl_if.sv | 28 ++
 rtl/paddle_ctrl.sv | 142 ++++++++++++++
 tb/tb_paddle_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/paddle_ctrl_if.sv
// Button, control and paddle-position bundle for paddle_ctrl.
// master drives buttons/controls, slave returns positions.
interface paddle_ctrl_if;
  logic       p1_up;
  logic       p1_dn;
  logic       p2_up;
  logic       p2_dn;
  logic       ai_en;
  logic       hold;
  logic       recentre;
  logic [9:0] ball_y;
  logic [9:0] p_1;
  logic [9:0] p_2;
  logic       tick;
  logic [3:0] btn_db;

  modport master (
    output p1_up, p1_dn, p2_up, p2_dn,
    output ai_en, hold, recentre, ball_y,
    input  p_1, p_2, tick, btn_db
  );

  modport slave (
    input  p1_up, p1_dn, p2_up, p2_dn,
    input  ai_en, hold, recentre, ball_y,
    output p_1, p_2, tick, btn_db
  );
endinterface

// File: rtl/paddle_ctrl.sv
// Pong paddle controller: button sync/debounce, tick divider,
// clamped human/AI paddle motion.
module paddle_ctrl #(
  parameter int TICK_DIV = 833333,
  parameter int DB_COUNT = 500000,
  parameter int PSTEP    = 4,
  parameter int AI_STEP  = 3,
  parameter int AI_DEAD  = 8,
  parameter int PHEIGHT  = 40,
  parameter int Y_MAX    = 480,
  parameter int Y_CENTRE = 240
) (
  input  logic          clk,
  input  logic          reset,
  paddle_ctrl_if.slave  bus
);

  localparam logic [19:0] TICK_LAST = 20'(TICK_DIV - 1);
  localparam logic [19:0] DB_LAST   = 20'(DB_COUNT - 1);

  // Comparisons use 11 bits so p - step / p + dead never wrap.
  localparam logic [10:0] L_PSTEP = 11'(PSTEP);
  localparam logic [10:0] L_AISTP = 11'(AI_STEP);
  localparam logic [10:0] L_DEAD  = 11'(AI_DEAD);
  localparam logic [10:0] L_LO    = 11'(PHEIGHT);
  localparam logic [10:0] L_HI    = 11'(Y_MAX - PHEIGHT);

  localparam logic [9:0] P_PSTEP = 10'(PSTEP);
  localparam logic [9:0] P_AISTP = 10'(AI_STEP);
  localparam logic [9:0] P_LO    = 10'(PHEIGHT);
  localparam logic [9:0] P_HI    = 10'(Y_MAX - PHEIGHT);
  localparam logic [9:0] P_MID   = 10'(Y_CENTRE);

  logic [3:0]  w_raw;
  logic [3:0]  r_sync1;
  logic [3:0]  r_sync2;
  logic [3:0]  r_db;
  logic [19:0] r_dbcnt [4];
  logic [19:0] r_tcnt;
  logic        w_tick;
  logic [9:0]  r_p1;
  logic [9:0]  r_p2;
  logic [9:0]  w_p1_nxt;
  logic [9:0]  w_p2_nxt;

  assign w_raw = {bus.p2_dn, bus.p2_up, bus.p1_dn, bus.p1_up};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      for (int i = 0; i < 4; i++) r_dbcnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_dbcnt[i] <= '0;
        end else if (r_dbcnt[i] == DB_LAST) begin
          r_db[i]    <= r_sync2[i];
          r_dbcnt[i] <= '0;
        end else begin
          r_dbcnt[i] <= r_dbcnt[i] + 20'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_tcnt <= '0;
    else if (r_tcnt == TICK_LAST)
      r_tcnt <= '0;
    else
      r_tcnt <= r_tcnt + 20'd1;
  end

  assign w_tick = (r_tcnt == TICK_LAST);

  function automatic logic [9:0] f_human(
    input logic [9:0] p,
    input logic       up,
    input logic       dn
  );
    logic [9:0] res;
    res = p;
    unique case ({up, dn})
      2'b10: res = ({1'b0, p} - L_PSTEP < L_LO) ?
                   P_LO : p - P_PSTEP;
      2'b01: res = ({1'b0, p} + L_PSTEP > L_HI) ?
                   P_HI : p + P_PSTEP;
      default: res = p;
    endcase
    return res;
  endfunction

  function automatic logic [9:0] f_ai(
    input logic [9:0] p,
    input logic [9:0] by
  );
    logic [9:0] res;
    res = p;
    if ({1'b0, by} > {1'b0, p} + L_DEAD)
      res = ({1'b0, p} + L_AISTP > L_HI) ?
            P_HI : p + P_AISTP;
    else if ({1'b0, by} + L_DEAD < {1'b0, p})
      res = ({1'b0, p} - L_AISTP < L_LO) ?
            P_LO : p - P_AISTP;
    return res;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p1 <= P_MID;
      r_p2 <= P_MID;
    end else begin
      r_p1 <= w_p1_nxt;
      r_p2 <= w_p2_nxt;
    end
  end

  // recentre beats hold, hold beats tick
  always_comb begin
    w_p1_nxt = r_p1;
    w_p2_nxt = r_p2;
    if (bus.recentre) begin
      w_p1_nxt = P_MID;
      w_p2_nxt = P_MID;
    end else if (!bus.hold && w_tick) begin
      w_p1_nxt = f_human(r_p1, r_db[0], r_db[1]);
      w_p2_nxt = bus.ai_en ? f_ai(r_p2, bus.ball_y)
                           : f_human(r_p2, r_db[2], r_db[3]);
    end
  end

  assign bus.p_1    = r_p1;
  assign bus.p_2    = r_p2;
  assign bus.tick   = w_tick;
  assign bus.btn_db = r_db;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Randomised and directed bench for paddle_ctrl against a
// cycle-level behavioural model.
module tb_paddle_ctrl;
  localparam int TD = 4;
  localparam int DB = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  paddle_ctrl_if ifc ();

  paddle_ctrl #(
    .TICK_DIV (TD),
    .DB_COUNT (DB)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  int mp1;
  int mp2;
  int mcnt;
  logic [3:0] mdb;
  logic [3:0] rq [$];

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_chk++;
    if (act == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d want %0d at %0t",
               nm, act, exp, $time);
  endtask

  function automatic int clamp(input int v);
    if (v < 40) return 40;
    if (v > 440) return 440;
    return v;
  endfunction

  function automatic int human(input int p, input logic up,
                               input logic dn);
    if (up && !dn) return clamp(p - 4);
    if (dn && !up) return clamp(p + 4);
    return p;
  endfunction

  task automatic mreset();
    mp1 = 240;
    mp2 = 240;
    mcnt = 0;
    mdb = '0;
    rq = {};
    repeat (DB + 2) rq.push_front(4'b0);
  endtask

  // A button flips once the last DB synchronised samples
  // all disagree with its debounced value.
  task automatic mstep(input logic [3:0] raw, input logic ai,
                       input logic hld, input logic rec,
                       input int by);
    bit tk;
    bit flip;
    tk = (mcnt % TD == TD - 1);
    if (rec) begin
      mp1 = 240;
      mp2 = 240;
    end else if (!hld && tk) begin
      mp1 = human(mp1, mdb[0], mdb[1]);
      if (ai) begin
        if (by > mp2 + 8) mp2 = clamp(mp2 + 3);
        else if (by < mp2 - 8) mp2 = clamp(mp2 - 3);
      end else begin
        mp2 = human(mp2, mdb[2], mdb[3]);
      end
    end
    rq.push_front(raw);
    void'(rq.pop_back());
    for (int i = 0; i < 4; i++) begin
      flip = 1'b1;
      for (int k = 2; k < DB + 2; k++)
        if (rq[k][i] == mdb[i]) flip = 1'b0;
      if (flip) mdb[i] = ~mdb[i];
    end
    mcnt++;
  endtask

  initial begin
    mreset();
    forever begin
      @(posedge clk);
      if (reset)
        mreset();
      else
        mstep({ifc.p2_dn, ifc.p2_up, ifc.p1_dn, ifc.p1_up},
              ifc.ai_en, ifc.hold, ifc.recentre,
              int'(ifc.ball_y));
      @(negedge clk);
      if (reset) mreset();
      chk("p_1", int'(ifc.p_1), mp1);
      chk("p_2", int'(ifc.p_2), mp2);
      chk("tick", int'(ifc.tick), int'(mcnt % TD == TD - 1));
      chk("btn_db", int'(ifc.btn_db), int'(mdb));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    ifc.p1_up = 0;
    ifc.p1_dn = 0;
    ifc.p2_up = 0;
    ifc.p2_dn = 0;
    ifc.ai_en = 0;
    ifc.hold = 0;
    ifc.recentre = 0;
    ifc.ball_y = '0;
    step(3);
    reset = 1'b0;

    step(1);
    chk("rst_p1", int'(ifc.p_1), 240);
    chk("rst_p2", int'(ifc.p_2), 240);
    chk("rst_db", int'(ifc.btn_db), 0);
    chk("tick_lo", int'(ifc.tick), 0);
    step(2);
    chk("tick_hi", int'(ifc.tick), 1);
    step(1);
    chk("tick_wrap", int'(ifc.tick), 0);

    ifc.p1_up = 1;
    ifc.p1_dn = 1;
    step(50);
    chk("both_held", int'(ifc.p_1), 240);
    ifc.p1_up = 0;
    ifc.p1_dn = 0;
    step(10);

    ifc.p1_up = 1;
    step(4);
    chk("db_early", int'(ifc.btn_db[0]), 0);
    step(1);
    chk("db_rise", int'(ifc.btn_db[0]), 1);
    step(220);
    chk("p1_floor", int'(ifc.p_1), 40);
    ifc.p1_up = 0;
    step(10);

    ifc.p2_dn = 1;
    step(2);
    ifc.p2_dn = 0;
    step(20);
    chk("glitch_db", int'(ifc.btn_db[3]), 0);
    chk("glitch_p2", int'(ifc.p_2), 240);

    ifc.ai_en = 1;
    ifc.ball_y = 10'd400;
    step(4 * 60);
    chk("ai_stop", int'(ifc.p_2), 393);
    ifc.ball_y = 10'd500;
    step(100);
    chk("ai_top", int'(ifc.p_2), 440);

    ifc.p1_dn = 1;
    for (int i = 0; i < 400; i++) begin
      step(1);
      if (ifc.p_1 == 10'd100) break;
    end
    ifc.hold = 1;
    chk("reach_p1_100", int'(ifc.p_1), 100);
    ifc.p1_dn = 0;
    step(10);
    chk("hold_p1", int'(ifc.p_1), 100);
    for (int i = 0; i < 8; i++) begin
      if (ifc.tick) break;
      step(1);
    end
    chk("tick_seen", int'(ifc.tick), 1);
    ifc.hold = 0;
    ifc.recentre = 1;
    step(1);
    chk("recentre_p1", int'(ifc.p_1), 240);
    chk("recentre_p2", int'(ifc.p_2), 240);
    ifc.recentre = 0;
    ifc.hold = 1;
    ifc.p1_dn = 1;
    step(20);
    chk("hold_dn", int'(ifc.p_1), 240);
    ifc.hold = 0;
    ifc.p1_dn = 0;
    ifc.ai_en = 0;

    ifc.p1_up = 1;
    step(30);
    reset = 1'b1;
    step(2);
    chk("midrst_p1", int'(ifc.p_1), 240);
    chk("midrst_db", int'(ifc.btn_db), 0);
    reset = 1'b0;
    step(20);

    for (int c = 0; c < 2000; c++) begin
      if ($urandom % 10 == 0) ifc.p1_up = ~ifc.p1_up;
      if ($urandom % 10 == 0) ifc.p1_dn = ~ifc.p1_dn;
      if ($urandom % 10 == 0) ifc.p2_up = ~ifc.p2_up;
      if ($urandom % 10 == 0) ifc.p2_dn = ~ifc.p2_dn;
      if ($urandom % 40 == 0) ifc.hold = ~ifc.hold;
      ifc.recentre = ($urandom % 60 == 0);
      if ($urandom % 150 == 0) ifc.ai_en = ~ifc.ai_en;
      if ($urandom % 30 == 0)
        ifc.ball_y = 10'($urandom_range(0, 520));
      step(1);
    end

    step(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
